// File: rtl/systolic_ws_stream_dpath.sv
// Weight-stationary LENGTH x COL_NUM systolic GEMM: weight preload FSM, input skew, output deskew, valid/last tracking.
// Latency LENGTH+COL_NUM-1 from input fire to out_val; one vector/cycle; no output backpressure (consumer always accepts).
module systolic_ws_stream_dpath #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 4*DATA_WIDTH,
   parameter int LENGTH     = 8,
   parameter int COL_NUM    = 8,
   parameter bit SIGNED     = 1'b1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 w_val,
   output logic                                 w_rdy,
   input  logic [0:COL_NUM-1][DATA_WIDTH-1:0]   w_data,
   input  logic                                 in_val,
   output logic                                 in_rdy,
   input  logic                                 in_last,
   input  logic [0:LENGTH-1][DATA_WIDTH-1:0]    in_data,
   output logic                                 out_val,
   output logic                                 out_last,
   output logic [0:COL_NUM-1][ACC_WIDTH-1:0]    out_data,
   output logic                                 busy
);
   localparam int LEN_ADDR_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int LAT_WIDTH      = $clog2(LENGTH + COL_NUM);
   localparam int LAT            = LENGTH + COL_NUM - 1;
   localparam int PW             = 2*DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

   state_t                    state_q, state_d;
   logic [LEN_ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d, wr_row;
   logic [LAT_WIDTH-1:0]      drain_cnt_q, drain_cnt_d;
   logic                      w_fire, in_fire;

   logic [DATA_WIDTH-1:0] wgt_q  [0:LENGTH-1][0:COL_NUM-1];
   logic [DATA_WIDTH-1:0] wgt_d  [0:LENGTH-1][0:COL_NUM-1];
   logic [DATA_WIDTH-1:0] skew_q [0:LENGTH-1][0:LENGTH-1];
   logic [DATA_WIDTH-1:0] skew_d [0:LENGTH-1][0:LENGTH-1];
   logic [DATA_WIDTH-1:0] skw    [0:LENGTH-1][0:LENGTH-1];
   logic [DATA_WIDTH-1:0] east_q [0:LENGTH-1][0:COL_NUM-1];
   logic [DATA_WIDTH-1:0] east_d [0:LENGTH-1][0:COL_NUM-1];
   logic [DATA_WIDTH-1:0] wi     [0:LENGTH-1][0:COL_NUM-1];
   logic [ACC_WIDTH-1:0]  sum_q  [0:LENGTH-1][0:COL_NUM-1];
   logic [ACC_WIDTH-1:0]  sum_d  [0:LENGTH-1][0:COL_NUM-1];
   logic [ACC_WIDTH-1:0]  ni     [0:LENGTH-1][0:COL_NUM-1];
   logic [ACC_WIDTH-1:0]  desk_q [0:COL_NUM-1][0:COL_NUM-1];
   logic [ACC_WIDTH-1:0]  desk_d [0:COL_NUM-1][0:COL_NUM-1];
   logic [ACC_WIDTH-1:0]  dk     [0:COL_NUM-1][0:COL_NUM-1];

   logic [0:COL_NUM-1][ACC_WIDTH-1:0] col_out, hold_q, hold_d;
   logic [LAT-1:0] vld_q, vld_d, last_q, last_d;

   function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
      logic signed [PW-1:0] ps;
      logic        [PW-1:0] pu;
      ps = PW'($signed(a)) * PW'($signed(b));
      pu = PW'(a) * PW'(b);
      if (SIGNED) return ACC_WIDTH'(ps);
      else        return ACC_WIDTH'(pu);
   endfunction

   always_comb begin : fsm
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      drain_cnt_d = drain_cnt_q;
      wgt_d       = wgt_q;
      wr_row      = row_cnt_q;
      w_rdy       = 1'b0;
      in_rdy      = 1'b0;
      case (state_q)
         IDLE: begin
            w_rdy  = !reset;
            wr_row = '0;
            if (w_val && w_rdy) begin
               row_cnt_d = LEN_ADDR_WIDTH'(1);
               state_d   = (LENGTH == 1) ? STREAM : LOAD;
            end
         end
         LOAD: begin
            w_rdy = !reset;
            if (w_val && w_rdy) begin
               row_cnt_d = row_cnt_q + LEN_ADDR_WIDTH'(1);
               if (row_cnt_q == LEN_ADDR_WIDTH'(LENGTH-1)) state_d = STREAM;
            end
         end
         STREAM: begin
            in_rdy = !reset;
            if (in_val && in_rdy && in_last) begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == LAT_WIDTH'(LAT-1)) state_d = IDLE;
            else drain_cnt_d = drain_cnt_q + LAT_WIDTH'(1);
         end
         default: state_d = IDLE;
      endcase
      w_fire  = w_val && w_rdy;
      in_fire = in_val && in_rdy;
      for (int k = 0; k < LENGTH; k++)
         for (int j = 0; j < COL_NUM; j++)
            if (w_fire && (wr_row == LEN_ADDR_WIDTH'(k))) wgt_d[k][j] = w_data[j];
   end

   always_comb begin : dpath
      // Non-fire cycles inject zeros so bubbles and drain never disturb live partial sums.
      for (int k = 0; k < LENGTH; k++) begin
         skw[k][0] = in_fire ? in_data[k] : '0;
         for (int s = 1; s < LENGTH; s++) skw[k][s] = skew_q[k][s-1];
         for (int s = 0; s < LENGTH; s++) skew_d[k][s] = (s < k) ? skw[k][s] : '0;
         wi[k][0] = skw[k][k];
         for (int j = 1; j < COL_NUM; j++) wi[k][j] = east_q[k][j-1];
      end
      for (int j = 0; j < COL_NUM; j++) begin
         ni[0][j] = '0;
         for (int k = 1; k < LENGTH; k++) ni[k][j] = sum_q[k-1][j];
      end
      for (int k = 0; k < LENGTH; k++)
         for (int j = 0; j < COL_NUM; j++) begin
            east_d[k][j] = (j < COL_NUM-1) ? wi[k][j] : '0;
            sum_d[k][j]  = ni[k][j] + mul_ext(wi[k][j], wgt_q[k][j]);
         end
      for (int j = 0; j < COL_NUM; j++) begin
         dk[j][0] = sum_q[LENGTH-1][j];
         for (int s = 1; s < COL_NUM; s++) dk[j][s] = desk_q[j][s-1];
         for (int s = 0; s < COL_NUM; s++) desk_d[j][s] = (s < COL_NUM-1-j) ? dk[j][s] : '0;
         col_out[j] = dk[j][COL_NUM-1-j];
      end
      vld_d     = '0;
      last_d    = '0;
      vld_d[0]  = in_fire;
      last_d[0] = in_fire && in_last;
      for (int i = 1; i < LAT; i++) begin
         vld_d[i]  = vld_q[i-1];
         last_d[i] = last_q[i-1];
      end
      hold_d = out_val ? col_out : hold_q;
   end

   assign out_val  = vld_q[LAT-1];
   assign out_last = last_q[LAT-1];
   assign out_data = out_val ? col_out : hold_q;
   assign busy     = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         row_cnt_q   <= '0;
         drain_cnt_q <= '0;
         wgt_q       <= '{default: '0};
         skew_q      <= '{default: '0};
         east_q      <= '{default: '0};
         sum_q       <= '{default: '0};
         desk_q      <= '{default: '0};
         vld_q       <= '0;
         last_q      <= '0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         wgt_q       <= wgt_d;
         skew_q      <= skew_d;
         east_q      <= east_d;
         sum_q       <= sum_d;
         desk_q      <= desk_d;
         vld_q       <= vld_d;
         last_q      <= last_d;
         hold_q      <= hold_d;
      end
   end
endmodule
